apb_uart_slave: RTL and testbench



---
 rtl/apb_uart_slave.sv | 181 ++++++++++++++++++
 tb/tb_apb_uart_slave.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_uart_slave.sv
// APB completer for the UART subsystem: register file, TX/RX byte FIFOs,
// and the valid/ready byte handshake towards the UART core.
module apb_uart_slave #(
    parameter int          FIFO_DEPTH  = 4,
    parameter int          WAIT_STATES = 1,
    parameter logic [15:0] DIV_RESET   = 16'd434
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [15:0] baud_div,
    output logic        irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state;
    logic [2:0]  wcnt;
    logic [2:0]  reg_sel;
    logic        is_write;
    logic [15:0] wdata;

    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
    logic [CW-1:0] tx_count, rx_count;
    logic          overrun;
    logic [3:0]    ctrl;

    logic tx_full, tx_empty, rx_full, rx_empty;
    logic tx_push, tx_pop, rx_push, rx_pop, rx_drop;
    logic ovr_clr, ctrl_we, baud_we, done;
    logic [31:0] rdata, status;
    logic err;
    logic unused_bits;

    assign unused_bits = ^{PADDR[31:5], PADDR[1:0], PWDATA[31:16]};

    // Address/direction/data are frozen in the setup cycle.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state    <= S_IDLE;
            wcnt     <= '0;
            reg_sel  <= '0;
            is_write <= 1'b0;
            wdata    <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (PSEL && !PENABLE) begin
                        reg_sel  <= PADDR[4:2];
                        is_write <= PWRITE;
                        wdata    <= PWDATA[15:0];
                        wcnt     <= 3'(WAIT_STATES);
                        state    <= (WAIT_STATES == 0) ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!PSEL)
                        state <= S_IDLE;
                    else if (wcnt <= 3'd1)
                        state <= S_DONE;
                    else
                        wcnt <= wcnt - 3'd1;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign done     = (state == S_DONE);
    assign tx_full  = (tx_count == FULL_CNT);
    assign tx_empty = (tx_count == '0);
    assign rx_full  = (rx_count == FULL_CNT);
    assign rx_empty = (rx_count == '0);
    assign tx_valid = ctrl[0] & ~tx_empty;
    assign tx_pop   = tx_valid & tx_ready;
    assign tx_data  = tx_mem[tx_rd];

    assign status = {16'b0, 4'(rx_count), 4'(tx_count), 3'b0,
                     overrun, rx_empty, rx_full, tx_empty, tx_full};

    always_comb begin
        rdata   = '0;
        err     = 1'b0;
        tx_push = 1'b0;
        rx_pop  = 1'b0;
        ovr_clr = 1'b0;
        ctrl_we = 1'b0;
        baud_we = 1'b0;
        if (done) begin
            unique case (reg_sel)
                3'd0: begin
                    // A core pop in the same cycle frees the slot.
                    if (is_write && tx_full && !tx_pop) err = 1'b1;
                    else if (is_write)                  tx_push = 1'b1;
                end
                3'd1: begin
                    if (is_write || rx_empty) begin
                        err = 1'b1;
                    end else begin
                        rx_pop = 1'b1;
                        rdata  = {24'b0, rx_mem[rx_rd]};
                    end
                end
                3'd2: begin
                    if (is_write) ovr_clr = wdata[4];
                    else          rdata   = status;
                end
                3'd3: begin
                    if (is_write) ctrl_we = 1'b1;
                    else          rdata   = {28'b0, ctrl};
                end
                3'd4: begin
                    if (is_write) baud_we = 1'b1;
                    else          rdata   = {16'b0, baud_div};
                end
                default: err = 1'b1;
            endcase
        end
    end

    assign PRDATA  = rdata;
    assign PSLVERR = err;
    assign PREADY  = done;

    assign rx_push = rx_valid & ctrl[1] & (~rx_full | rx_pop);
    assign rx_drop = rx_valid & ctrl[1] & rx_full & ~rx_pop;

    always_ff @(posedge PCLK) begin
        if (tx_push) tx_mem[tx_wr] <= wdata[7:0];
        if (rx_push) rx_mem[rx_wr] <= rx_data;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            tx_wr    <= '0;
            tx_rd    <= '0;
            tx_count <= '0;
            rx_wr    <= '0;
            rx_rd    <= '0;
            rx_count <= '0;
            overrun  <= 1'b0;
            ctrl     <= '0;
            baud_div <= DIV_RESET;
            irq      <= 1'b0;
        end else begin
            if (tx_push) tx_wr <= tx_wr + 1'b1;
            if (tx_pop)  tx_rd <= tx_rd + 1'b1;
            tx_count <= tx_count + CW'(tx_push) - CW'(tx_pop);
            if (rx_push) rx_wr <= rx_wr + 1'b1;
            if (rx_pop)  rx_rd <= rx_rd + 1'b1;
            rx_count <= rx_count + CW'(rx_push) - CW'(rx_pop);
            // A fresh overrun beats a simultaneous clear.
            overrun  <= rx_drop | (overrun & ~ovr_clr);
            if (ctrl_we) ctrl     <= wdata[3:0];
            if (baud_we) baud_div <= wdata;
            irq <= (ctrl[2] & ~rx_empty) | (ctrl[3] & tx_empty) | overrun;
        end
    end

endmodule

// File: tb/tb_apb_uart_slave.sv
// Self-checking bench for apb_uart_slave: directed plan steps plus a
// randomized phase against a queue-based register/FIFO model.
module tb_apb_uart_slave;

    localparam int          D  = 4;
    localparam int          WS = 1;
    localparam logic [15:0] DR = 16'd434;

    logic        PCLK = 1'b0;
    logic        PRESET, PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PREADY, PSLVERR;
    logic [7:0]  tx_data, rx_data;
    logic        tx_valid, tx_ready, rx_valid, irq;
    logic [15:0] baud_div;

    apb_uart_slave #(.FIFO_DEPTH(D), .WAIT_STATES(WS), .DIV_RESET(DR)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
        .rx_valid(rx_valid), .baud_div(baud_div), .irq(irq)
    );

    always #5 PCLK = ~PCLK;

    int checks = 0;
    int failures = 0;

    byte unsigned txq[$];
    byte unsigned rxq[$];
    bit           m_ovr;
    logic [3:0]   m_ctrl;
    logic [15:0]  m_baud;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        int t = txq.size();
        int r = rxq.size();
        int s = 0;
        if (t == D) s += 1;
        if (t == 0) s += 2;
        if (r == D) s += 4;
        if (r == 0) s += 8;
        if (m_ovr)  s += 16;
        s += t * 256 + r * 4096;
        return 32'(s);
    endfunction

    function automatic logic m_irq();
        return (m_ctrl[2] && rxq.size() != 0) ||
               (m_ctrl[3] && txq.size() == 0) || m_ovr;
    endfunction

    task automatic m_reset();
        txq.delete();
        rxq.delete();
        m_ovr  = 1'b0;
        m_ctrl = 4'h0;
        m_baud = DR;
    endtask

    task automatic m_rxpush(input logic [7:0] d);
        if (m_ctrl[1]) begin
            if (rxq.size() == D) m_ovr = 1'b1;
            else                 rxq.push_back(d);
        end
    endtask

    task automatic apb(input logic [31:0] addr, input logic wr,
                       input logic [31:0] wd, input logic inj,
                       input logic [7:0] injd, output logic [31:0] rd,
                       output logic err, output int lat);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0;
        PADDR = addr; PWRITE = wr; PWDATA = wd;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        PADDR = $urandom; PWRITE = 1'($urandom); PWDATA = $urandom;
        lat = 1;
        while (!PREADY && lat < 20) begin
            @(posedge PCLK); #1;
            lat++;
        end
        rd  = PRDATA;
        err = PSLVERR;
        if (inj) begin
            rx_valid = 1'b1;
            rx_data  = injd;
        end
        @(posedge PCLK); #1;
        rx_valid = 1'b0;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] wd,
                            input string tag);
        logic [31:0] rd;
        logic er;
        logic ee = 1'b0;
        int lat;
        case (addr[4:2])
            3'd0: if (txq.size() == D) ee = 1'b1;
                  else txq.push_back(wd[7:0]);
            3'd1: ee = 1'b1;
            3'd2: if (wd[4]) m_ovr = 1'b0;
            3'd3: m_ctrl = wd[3:0];
            3'd4: m_baud = wd[15:0];
            default: ee = 1'b1;
        endcase
        apb(addr, 1'b1, wd, 1'b0, 8'h00, rd, er, lat);
        chk({tag, "_lat"}, 32'(lat), 32'(WS + 1));
        chk({tag, "_err"}, 32'(er), 32'(ee));
    endtask

    task automatic do_read(input logic [31:0] addr, input logic inj,
                           input logic [7:0] injd, input string tag);
        logic [31:0] rd;
        logic [31:0] ed = '0;
        logic er;
        logic ee = 1'b0;
        int lat;
        case (addr[4:2])
            3'd0: ed = '0;
            3'd1: if (rxq.size() == 0) ee = 1'b1;
                  else ed = 32'(rxq.pop_front());
            3'd2: ed = m_status();
            3'd3: ed = 32'(m_ctrl);
            3'd4: ed = 32'(m_baud);
            default: ee = 1'b1;
        endcase
        if (inj) m_rxpush(injd);
        apb(addr, 1'b0, $urandom, inj, injd, rd, er, lat);
        chk({tag, "_lat"}, 32'(lat), 32'(WS + 1));
        chk({tag, "_data"}, rd, ed);
        chk({tag, "_err"}, 32'(er), 32'(ee));
    endtask

    task automatic rx_pulse(input logic [7:0] d);
        @(posedge PCLK); #1;
        rx_valid = 1'b1;
        rx_data  = d;
        @(posedge PCLK); #1;
        rx_valid = 1'b0;
        m_rxpush(d);
    endtask

    task automatic chk_irq(input string tag);
        @(posedge PCLK); #1;
        chk(tag, 32'(irq), 32'(m_irq()));
    endtask

    task automatic drain(input string tag);
        int n = txq.size();
        tx_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            chk({tag, "_valid"}, 32'(tx_valid), 32'd1);
            chk({tag, "_byte"}, 32'(tx_data), 32'(txq.pop_front()));
            @(posedge PCLK); #1;
        end
        chk({tag, "_empty"}, 32'(tx_valid), 32'd0);
        tx_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; tx_ready = 1'b0;
        rx_valid = 1'b0; rx_data = '0;
        m_reset();
        repeat (3) @(posedge PCLK);
        #1;
        chk("rst_pready", 32'(PREADY), 32'd0);
        chk("rst_prdata", PRDATA, 32'd0);
        chk("rst_pslverr", 32'(PSLVERR), 32'd0);
        chk("rst_txvalid", 32'(tx_valid), 32'd0);
        chk("rst_baud", 32'(baud_div), 32'(DR));
        chk("rst_irq", 32'(irq), 32'd0);
        PRESET = 1'b0;

        do_read(32'h08, 1'b0, 8'h00, "status0");
        chk("status0_const", m_status(), 32'h0000_000A);

        do_write(32'h0C, 32'h3, "ctrl_en");
        for (int i = 0; i < 5; i++)
            do_write(32'h00, 32'(8'h41 + i), $sformatf("txw%0d", i));
        do_read(32'h08, 1'b0, 8'h00, "tx_status");
        drain("txdrain");

        for (int i = 0; i < 5; i++) rx_pulse(8'(8'h10 + i));
        do_read(32'h08, 1'b0, 8'h00, "rx_status");
        for (int i = 0; i < 5; i++)
            do_read(32'h04, 1'b0, 8'h00, $sformatf("rxr%0d", i));
        do_write(32'h08, 32'h10, "w1c");
        do_read(32'h08, 1'b0, 8'h00, "w1c_status");

        for (int i = 0; i < 4; i++) rx_pulse(8'($urandom));
        do_read(32'h04, 1'b1, 8'h55, "rx_inj");
        do_read(32'h08, 1'b0, 8'h00, "inj_status");
        for (int i = 0; i < 4; i++)
            do_read(32'h04, 1'b0, 8'h00, $sformatf("inj_rd%0d", i));

        do_write(32'h10, 32'h0000_01B2, "baud_w");
        chk("baud_out", 32'(baud_div), 32'h01B2);
        do_read(32'h10, 1'b0, 8'h00, "baud_r");
        do_read(32'h18, 1'b0, 8'h00, "unmap18_r");
        do_write(32'h18, 32'hFFFF_FFFF, "unmap18_w");
        do_read(32'h14, 1'b0, 8'h00, "unmap14_r");
        do_write(32'h1C, 32'h0, "unmap1c_w");
        do_write(32'h0C, 32'hFFFF_FFF5, "ctrl_w");
        do_read(32'h0C, 1'b0, 8'h00, "ctrl_r");
        chk_irq("irq_txempty");
        do_write(32'h0C, 32'h6, "ctrl_rxirq");
        chk_irq("irq_rxempty");
        rx_pulse(8'h9A);
        chk_irq("irq_rxdata");

        for (int it = 0; it < 80; it++) begin
            int op = $urandom_range(0, 7);
            a = $urandom & ~32'h1C;
            case (op)
                0, 1: rx_pulse(8'($urandom));
                2: do_read(a | 32'h04, 1'b0, 8'h00, "rnd_rx");
                3: do_read(a | 32'h08, 1'b0, 8'h00, "rnd_stat");
                4: do_write(a, $urandom, "rnd_tx");
                5: do_write(a | 32'h08, $urandom, "rnd_w1c");
                6: do_write(a | 32'h0C, $urandom, "rnd_ctrl");
                default: do_read(a | 32'(4 * $urandom_range(0, 7)),
                                 1'b1, 8'($urandom), "rnd_any");
            endcase
            chk_irq("rnd_irq");
        end
        do_write(32'h0C, 32'h3, "ctrl_end");
        drain("rnd_drain");

        do_write(32'h0C, 32'h0, "ctrl_off");
        do_write(32'h00, 32'h99, "pre_rst_tx");
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h0; PWRITE = 1'b1;
        PWDATA = 32'h77;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        chk("wait_pready", 32'(PREADY), 32'd0);
        PRESET = 1'b1;
        @(posedge PCLK); #1;
        chk("mid_pready", 32'(PREADY), 32'd0);
        chk("mid_prdata", PRDATA, 32'd0);
        chk("mid_pslverr", 32'(PSLVERR), 32'd0);
        chk("mid_txvalid", 32'(tx_valid), 32'd0);
        chk("mid_baud", 32'(baud_div), 32'(DR));
        chk("mid_irq", 32'(irq), 32'd0);
        PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
        m_reset();
        do_read(32'h08, 1'b0, 8'h00, "post_rst_status");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
